// File: rtl/register_file_be_if.sv
// Bus bundle for register_file_be: one byte-enabled write port, clear, two registered read ports.
interface register_file_be_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 3
) ();
    logic               clr;
    logic               we;
    logic [AW-1:0]      wr_addr;
    logic [WIDTH/8-1:0] wr_be;
    logic [WIDTH-1:0]   wr_data;
    logic               rd_en0;
    logic [AW-1:0]      rd_addr0;
    logic [WIDTH-1:0]   rd_data0;
    logic               rd_en1;
    logic [AW-1:0]      rd_addr1;
    logic [WIDTH-1:0]   rd_data1;

    modport master (
        output clr, we, wr_addr, wr_be, wr_data, rd_en0, rd_addr0, rd_en1, rd_addr1,
        input  rd_data0, rd_data1
    );

    modport slave (
        input  clr, we, wr_addr, wr_be, wr_data, rd_en0, rd_addr0, rd_en1, rd_addr1,
        output rd_data0, rd_data1
    );
endinterface

// File: rtl/register_file_be.sv
// Byte-enabled register bank with synchronous clear and two registered read ports.
// Define REGFILE_WR_BYPASS_EN to forward a same-edge write (or clear) to the read ports.
module register_file_be #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AW        = 3,
    parameter bit          ZERO_REG0 = 1'b0
) (
    input logic               clk,
    input logic               reset,
    register_file_be_if.slave bus
);
    localparam int unsigned NB = WIDTH / 8;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] rd_data0_q, rd_data1_q;
    logic [WIDTH-1:0] rd_next0, rd_next1;
    logic [WIDTH-1:0] wr_old, wr_merged;
    logic             wr_ok;

    // A write lands only on an in-range word that is not the hard-wired zero word.
    always_comb begin
        wr_ok = (32'(bus.wr_addr) < DEPTH) && !(ZERO_REG0 && (bus.wr_addr == '0));
        wr_old = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (32'(bus.wr_addr) == i) wr_old = mem_q[i];
        end
        wr_merged = wr_old;
        for (int unsigned b = 0; b < NB; b++) begin
            if (bus.wr_be[b]) wr_merged[8*b +: 8] = bus.wr_data[8*b +: 8];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (bus.clr) begin
                mem_d[i] = '0;
            end else if (bus.we && wr_ok && (32'(bus.wr_addr) == i)) begin
                mem_d[i] = wr_merged;
            end
        end
        if (ZERO_REG0) mem_d[0] = '0;
    end

    always_comb begin
        rd_next0 = '0;
        rd_next1 = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((32'(bus.rd_addr0) == i) && !(ZERO_REG0 && (i == 0))) rd_next0 = mem_q[i];
            if ((32'(bus.rd_addr1) == i) && !(ZERO_REG0 && (i == 0))) rd_next1 = mem_q[i];
        end
`ifdef REGFILE_WR_BYPASS_EN
        if (bus.clr) begin
            rd_next0 = '0;
            rd_next1 = '0;
        end else if (bus.we && wr_ok) begin
            if (bus.rd_addr0 == bus.wr_addr) rd_next0 = wr_merged;
            if (bus.rd_addr1 == bus.wr_addr) rd_next1 = wr_merged;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_data0_q <= '0;
            rd_data1_q <= '0;
        end else begin
            mem_q <= mem_d;
            if (bus.rd_en0) rd_data0_q <= rd_next0;
            if (bus.rd_en1) rd_data1_q <= rd_next1;
        end
    end

    assign bus.rd_data0 = rd_data0_q;
    assign bus.rd_data1 = rd_data1_q;
endmodule

// File: tb/tb_register_file_be.sv
// Self-checking bench: default bank plus a DEPTH=6, ZERO_REG0=1 bank, against a word-level model.
module tb_register_file_be;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    register_file_be_if #(.WIDTH(32), .AW(3)) bus_a ();
    register_file_be_if #(.WIDTH(32), .AW(3)) bus_b ();

    register_file_be #(.WIDTH(32), .DEPTH(8), .AW(3), .ZERO_REG0(1'b0)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    register_file_be #(.WIDTH(32), .DEPTH(6), .AW(3), .ZERO_REG0(1'b1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] mdl [2][8];
    logic [31:0] exp0 [2];
    logic [31:0] exp1 [2];
    int          dep [2];
    bit          zr  [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                          input logic [31:0] wd);
        logic [31:0] mask;
        mask = '0;
        for (int b = 0; b < 4; b++) if (be[b]) mask = mask | (32'hFF << (8 * b));
        return (old & ~mask) | (wd & mask);
    endfunction

    function automatic bit writable(input int w, input int a);
        return (a < dep[w]) && !(zr[w] && a == 0);
    endfunction

    function automatic logic [31:0] exp_read(input int w, input int a, input bit c, input bit we,
                                             input int wa, input logic [3:0] be,
                                             input logic [31:0] wd);
        logic [31:0] v;
        v = (a >= dep[w] || (zr[w] && a == 0)) ? 32'h0 : mdl[w][a];
`ifdef REGFILE_WR_BYPASS_EN
        if (c) v = 32'h0;
        else if (we && a == wa && writable(w, wa)) v = merge(mdl[w][wa], be, wd);
`endif
        return v;
    endfunction

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 8; i++) mdl[w][i] = 32'h0;
            exp0[w] = 32'h0;
            exp1[w] = 32'h0;
        end
    endtask

    task automatic drive(input int w, input bit c, input bit we, input int wa, input logic [3:0] be,
                         input logic [31:0] wd, input bit re0, input int ra0, input bit re1,
                         input int ra1);
        if (w == 0) begin
            bus_a.clr = c; bus_a.we = we; bus_a.wr_addr = 3'(wa); bus_a.wr_be = be;
            bus_a.wr_data = wd; bus_a.rd_en0 = re0; bus_a.rd_addr0 = 3'(ra0);
            bus_a.rd_en1 = re1; bus_a.rd_addr1 = 3'(ra1);
        end else begin
            bus_b.clr = c; bus_b.we = we; bus_b.wr_addr = 3'(wa); bus_b.wr_be = be;
            bus_b.wr_data = wd; bus_b.rd_en0 = re0; bus_b.rd_addr0 = 3'(ra0);
            bus_b.rd_en1 = re1; bus_b.rd_addr1 = 3'(ra1);
        end
    endtask

    // One clock of traffic on bank w; the model advances and both read ports are checked.
    task automatic step(input string tag, input int w, input bit c, input bit we, input int wa,
                        input logic [3:0] be, input logic [31:0] wd, input bit re0, input int ra0,
                        input bit re1, input int ra1);
        logic [31:0] e0, e1;
        drive(w, c, we, wa, be, wd, re0, ra0, re1, ra1);
        e0 = re0 ? exp_read(w, ra0, c, we, wa, be, wd) : exp0[w];
        e1 = re1 ? exp_read(w, ra1, c, we, wa, be, wd) : exp1[w];
        @(posedge clk);
        #1;
        if (c) begin
            for (int i = 0; i < 8; i++) mdl[w][i] = 32'h0;
        end else if (we && writable(w, wa)) begin
            mdl[w][wa] = merge(mdl[w][wa], be, wd);
        end
        exp0[w] = e0;
        exp1[w] = e1;
        check({tag, "_p0"}, (w == 0) ? bus_a.rd_data0 : bus_b.rd_data0, e0);
        check({tag, "_p1"}, (w == 0) ? bus_a.rd_data1 : bus_b.rd_data1, e1);
        drive(w, 1'b0, 1'b0, 0, 4'h0, 32'h0, 1'b0, ra0, 1'b0, ra1);
    endtask

    task automatic wr(input int w, input int a, input logic [3:0] be, input logic [31:0] d);
        step("wr", w, 1'b0, 1'b1, a, be, d, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic rd(input string tag, input int w, input int a0, input int a1);
        step(tag, w, 1'b0, 1'b0, 0, 4'h0, 32'h0, 1'b1, a0, 1'b1, a1);
    endtask

    initial begin
        dep[0] = 8; dep[1] = 6;
        zr[0]  = 1'b0; zr[1] = 1'b1;
        model_reset();
        drive(0, 1'b0, 1'b0, 0, 4'h0, 32'h0, 1'b0, 0, 1'b0, 0);
        drive(1, 1'b0, 1'b0, 0, 4'h0, 32'h0, 1'b0, 0, 1'b0, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_p0", bus_a.rd_data0, 32'h0);
        check("rst_b_p1", bus_b.rd_data1, 32'h0);
        reset = 1'b0;

        // Asynchronous reset while rd_data0 holds a value
        wr(0, 0, 4'hF, 32'hDEADBEEF);
        rd("hold_dead", 0, 0, 0);
        check("dead_loaded", bus_a.rd_data0, 32'hDEADBEEF);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_p0", bus_a.rd_data0, 32'h0);
        check("rst_async_p1", bus_a.rd_data1, 32'h0);
        model_reset();
        // A write presented while reset is held is discarded
        drive(0, 1'b0, 1'b1, 2, 4'hF, 32'h55AA55AA, 1'b0, 0, 1'b0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, 0, 4'h0, 32'h0, 1'b0, 0, 1'b0, 0);
        for (int i = 0; i < 8; i++) rd("post_rst_a", 0, i, 7 - i);
        for (int i = 0; i < 8; i++) rd("post_rst_b", 1, i, 7 - i);

        // Byte-lane write
        wr(0, 3, 4'hF, 32'h11223344);
        wr(0, 3, 4'b0101, 32'hAABBCCDD);
        rd("be_read", 0, 0, 3);
        check("be_const", bus_a.rd_data1, 32'h11BB33DD);

        // Dual read then hold with changed addresses
        wr(0, 1, 4'hF, 32'h1);
        wr(0, 2, 4'hF, 32'h2);
        rd("dual", 0, 1, 2);
        check("dual_p0_const", bus_a.rd_data0, 32'h1);
        check("dual_p1_const", bus_a.rd_data1, 32'h2);
        for (int k = 0; k < 3; k++) begin
            step("hold", 0, 1'b0, 1'b0, 0, 4'h0, 32'h0, 1'b0, 3 + k, 1'b0, 4 + k);
        end
        check("hold_p0_const", bus_a.rd_data0, 32'h1);
        check("hold_p1_const", bus_a.rd_data1, 32'h2);

        // Same-edge write and read of addr 5
        wr(0, 5, 4'hF, 32'hCAFEF00D);
        step("wr_rd5", 0, 1'b0, 1'b1, 5, 4'h1, 32'h00000001, 1'b1, 5, 1'b0, 0);
`ifdef REGFILE_WR_BYPASS_EN
        check("wr_rd5_const", bus_a.rd_data0, 32'hCAFEF001);
`else
        check("wr_rd5_const", bus_a.rd_data0, 32'hCAFEF00D);
`endif
        rd("rd5_after", 0, 5, 5);
        check("rd5_after_const", bus_a.rd_data1, 32'hCAFEF001);

        // Clear beats a same-edge write
        step("clr_wr", 0, 1'b1, 1'b1, 4, 4'hF, 32'h12345678, 1'b0, 0, 1'b1, 4);
        for (int i = 0; i < 8; i++) rd("post_clr", 0, i, i);
        check("clr_addr4_const", bus_a.rd_data0, 32'h0);

        // Zero word and out-of-range on the DEPTH=6 bank
        for (int i = 1; i < 6; i++) wr(1, i, 4'hF, 32'h01010101 * i);
        wr(1, 0, 4'hF, 32'hFFFFFFFF);
        wr(1, 7, 4'hF, 32'hFFFFFFFF);
        rd("zr_oor", 1, 0, 7);
        check("zr0_const", bus_b.rd_data0, 32'h0);
        check("oor7_const", bus_b.rd_data1, 32'h0);
        for (int i = 1; i < 6; i++) rd("zr_keep", 1, i, i);
        check("zr_keep5_const", bus_b.rd_data0, 32'h05050505);

        // Randomized traffic on both banks
        for (int n = 0; n < 600; n++) begin
            int w, wa, ra0, ra1;
            bit c, we, re0, re1;
            w   = n % 2;
            c   = ($urandom_range(0, 24) == 0);
            we  = 1'($urandom_range(0, 1));
            wa  = $urandom_range(0, 7);
            re0 = 1'($urandom_range(0, 1));
            re1 = 1'($urandom_range(0, 1));
            ra0 = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, 7);
            ra1 = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, 7);
            step("rand", w, c, we, wa, 4'($urandom), $urandom, re0, ra0, re1, ra1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
